// File: rtl/seq_mult16_ctrl.sv
// Sequential 16x16 unsigned shift-add multiplier with valid/ready handshakes.
// One multiplier bit is consumed per RUN cycle through a single partial-product stage.

// Single operand-by-bit AND stage shared by every RUN cycle.
module seq_mult16_pp_stage (
  input  logic [15:0] a_i,
  input  logic        b_bit_i,
  output logic [15:0] pp_o
);
  assign pp_o = a_i & {16{b_bit_i}};
endmodule

module seq_mult16_ctrl #(
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] input1_i,
  input  logic [15:0] input2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] pp_s;
  logic [31:0] pp_ext_s;
  logic [15:0] b_rem_s;
  logic        upper_zero_s;

  seq_mult16_pp_stage u_pp_stage (
    .a_i     (a_q),
    .b_bit_i (b_q[cnt_q]),
    .pp_o    (pp_s)
  );

  assign pp_ext_s     = {16'd0, pp_s};
  // Multiplier bits above the one being processed this cycle are all zero.
  assign b_rem_s      = b_q >> cnt_q;
  assign upper_zero_s = ((b_rem_s >> 1) == 16'd0);

  // State, datapath and registered-output flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      acc_q       <= 32'd0;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = input1_i;
          b_d     = input2_i;
          acc_d   = 32'd0;
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + (pp_ext_s << cnt_q);
        cnt_d = cnt_q + 4'd1;
        if ((cnt_q == 4'd15) || ((EARLY_TERM == 1'b1) && upper_zero_s)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d  = 1'b0;
    busy_d      = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      ST_IDLE: in_ready_d  = 1'b1;
      ST_RUN:  busy_d      = 1'b1;
      ST_DONE: out_valid_d = 1'b1;
      default: in_ready_d  = 1'b1;
    endcase
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = acc_q;

endmodule

// File: tb/tb_seq_mult16_ctrl.sv
// Directed and randomized checks of seq_mult16_ctrl with EARLY_TERM=0 (dut 0)
// and EARLY_TERM=1 (dut 1); inputs change and outputs are sampled on negedge.
module tb_seq_mult16_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [15:0] in1       [2];
  logic [15:0] in2       [2];
  logic [31:0] res       [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_mult16_ctrl #(.EARLY_TERM(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .input1_i(in1[0]), .input2_i(in2[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .result_o(res[0]), .busy_o(busy[0])
  );

  seq_mult16_ctrl #(.EARLY_TERM(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .input1_i(in1[1]), .input2_i(in2[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .result_o(res[1]), .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int et, input logic [15:0] b);
    int hb;
    hb = 0;
    if (et == 0) return 16;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) hb = i + 1;
    end
    return (hb < 1) ? 1 : hb;
  endfunction

  task automatic check_reset_outputs(input int et);
    check("rst_in_ready",  32'(in_ready[et]),  32'd1);
    check("rst_busy",      32'(busy[et]),      32'd0);
    check("rst_out_valid", 32'(out_valid[et]), 32'd0);
    check("rst_result",    res[et],            32'd0);
  endtask

  // Caller is at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input int et, input logic [15:0] a, input logic [15:0] b, input int stall);
    int          lat;
    int          busy_cnt;
    int          want;
    logic [31:0] prod;
    prod = {16'd0, a} * {16'd0, b};
    want = exp_lat(et, b);
    check("ready_before_accept", 32'(in_ready[et]), 32'd1);
    in_valid[et]  = 1'b1;
    in1[et]       = a;
    in2[et]       = b;
    out_ready[et] = 1'b1;
    @(negedge clk);
    in_valid[et] = 1'b0;
    in1[et]      = ~a;
    in2[et]      = ~b;
    lat          = 0;
    busy_cnt     = 0;
    while (!out_valid[et] && lat < 40) begin
      if (busy[et]) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("latency",     32'(lat),      32'(want));
    check("busy_cycles", 32'(busy_cnt), 32'(want));
    check("result",      res[et],       prod);
    check("done_ready",  32'(in_ready[et]), 32'd0);
    check("done_busy",   32'(busy[et]),     32'd0);
    out_ready[et] = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      in_valid[et] = i[0];
      in1[et]      = 16'h0001;
      in2[et]      = 16'h0001;
      @(negedge clk);
      check("stall_result", res[et],                prod);
      check("stall_valid",  32'(out_valid[et]),     32'd1);
      check("stall_ready",  32'(in_ready[et]),      32'd0);
    end
    out_ready[et] = 1'b1;
    in_valid[et]  = 1'b1;
    @(negedge clk);
    check("handoff_ready", 32'(in_ready[et]),  32'd1);
    check("handoff_valid", 32'(out_valid[et]), 32'd0);
    check("handoff_busy",  32'(busy[et]),      32'd0);
    check("result_kept",   res[et],            prod);
    in_valid[et]  = 1'b0;
    out_ready[et] = 1'b0;
  endtask

  initial begin
    int          saw;
    logic [15:0] ra;
    logic [15:0] rb;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      in1[i]       = 16'd0;
      in2[i]       = 16'd0;
    end
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 16'hFFFF, 16'hFFFF, 0);
    run_op(1, 16'h0003, 16'h0005, 0);
    run_op(1, 16'h1234, 16'h0000, 0);
    run_op(0, 16'h1234, 16'h0000, 0);
    run_op(0, 16'h00FF, 16'h0100, 5);
    run_op(1, 16'h00FF, 16'h0100, 5);
    run_op(1, 16'hFFFF, 16'h8000, 2);
    run_op(0, 16'h0000, 16'hFFFF, 1);

    // Reset dropped in during the seventh RUN cycle must discard the operation.
    in_valid[0] = 1'b1;
    in1[0]      = 16'hABCD;
    in2[0]      = 16'h8001;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_rst", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] || out_valid[1]) saw = 1;
    end
    check("no_valid_after_rst", 32'(saw), 32'd0);

    // First accept on the very first edge after reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h0002, 16'h0002, 0);
    run_op(1, 16'h0002, 16'h0002, 0);

    for (int et = 0; et < 2; et++) begin
      for (int k = 0; k < 1000; k++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rb = rb >> $urandom_range(0, 16);
        run_op(et, ra, rb, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
